// File: rtl/pll_clk_monitor.sv
// PLL output monitor: synchronises lock and clkout into clk_tb, measures clkout
// edges over back-to-back gate windows after lock settles, and counts errors.
module pll_clk_monitor #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 64,
  parameter int EXP_COUNT     = 50,
  parameter int TOL           = 1,
  parameter int CNT_W         = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pll_lock,
  input  logic             clk_meas,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             freq_err,
  output logic             locked_stable,
  output logic             lock_loss,
  output logic [ERR_W-1:0] lock_loss_cnt,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_COUNT);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  state_t            state;
  logic [2:0]        lock_sync, meas_sync;
  logic [SW-1:0]     settle_cnt;
  logic [GW-1:0]     gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              lock_s, lock_fall, meas_rise;
  logic signed [CNT_W:0] diff;
  logic              win_err;

  // [1] is the synchronised value, [2] its one-cycle-old copy for edge detection
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      meas_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[1:0], pll_lock};
      meas_sync <= {meas_sync[1:0], clk_meas};
    end
  end

  assign lock_s    = lock_sync[1];
  assign lock_fall = lock_sync[2] & ~lock_sync[1];
  assign meas_rise = meas_sync[1] & ~meas_sync[2];

  // one extra bit keeps the subtraction signed without wrapping
  assign diff    = $signed({1'b0, edge_cnt}) - EXP_S;
  assign win_err = (diff > TOL_S) || (diff < -TOL_S);

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      meas_valid    <= 1'b0;
      meas_count    <= '0;
      freq_err      <= 1'b0;
      locked_stable <= 1'b0;
      lock_loss     <= 1'b0;
      lock_loss_cnt <= '0;
      err_cnt       <= '0;
    end else begin
      meas_valid <= 1'b0;
      lock_loss  <= 1'b0;
      case (state)
        IDLE: begin
          settle_cnt <= '0;
          if (enable && lock_s) state <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state         <= MEASURE;
            gate_cnt      <= '0;
            edge_cnt      <= '0;
            locked_stable <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (meas_rise && edge_cnt != '1) edge_cnt <= edge_cnt + 1'b1;
          if (gate_cnt == GW'(GATE_CYCLES - 1)) state <= REPORT;
          else                                  gate_cnt <= gate_cnt + 1'b1;
        end
        REPORT: begin
          meas_valid <= 1'b1;
          meas_count <= edge_cnt;
          freq_err   <= win_err;
          if (win_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          state      <= MEASURE;
        end
        default: state <= IDLE;
      endcase
      // lock drop / disable override everything; a report in flight still lands
      if (state != IDLE && (lock_fall || !enable)) begin
        state         <= IDLE;
        locked_stable <= 1'b0;
        if (lock_fall) begin
          lock_loss <= 1'b1;
          if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
      end
    end
  end
endmodule
